tt_vector_player: RTL

- Synthesizable, parametrised stimulus/capture engine for Tiny Tapeout style pin interfaces.
- Holds a small buffer of test vectors. Each vector is a stimulus word plus an expected response word.
- Replays the buffer onto a DUT's dedicated inputs at a programmable rate, compares the DUT outputs against the expected words, and reports the mismatch count and the index of the first failing vector.
- Sits between a host/config path and a user project; used for on-chip self-test and for bench bring-up of the core.

---
 rtl/tt_vector_player.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/tt_vector_player.sv
`default_nettype none
// ============================================================================
// Module   : tt_vector_player
// Brief    : Replays stored stimulus vectors onto a DUT and counts response
//            mismatches against the stored expected words.
// Revision : 1.0
// ============================================================================
module tt_vector_player #(
    parameter int IO_W  = 8,
    parameter int DEPTH = 16,
    parameter int DIV_W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [2*IO_W-1:0]                wr_data,
    output logic                             wr_full,
    input  logic                             start,
    input  logic                             loop_en,
    input  logic [DIV_W-1:0]                 div,
    output logic [IO_W-1:0]                  stim_out,
    input  logic [IO_W-1:0]                  obs_in,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(DEPTH+1)+8-1:0]     mismatch_cnt,
    output logic [$clog2(DEPTH)-1:0]         first_fail
);

    localparam int C_CNT_W = $clog2(DEPTH + 1);
    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_MC_W  = C_CNT_W + 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IO_W-1:0]      r_stim_mem [DEPTH];
    logic [IO_W-1:0]      r_exp_mem  [DEPTH];
    logic [C_CNT_W-1:0]   r_count, w_count_nxt;
    logic [C_IDX_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [C_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [C_IDX_W-1:0]   r_first_fail, w_first_fail_nxt;
    logic [DIV_W-1:0]     r_timer, w_timer_nxt;
    logic [C_MC_W-1:0]    r_mcnt, w_mcnt_nxt;
    logic [IO_W-1:0]      r_stim, w_stim_nxt;

    logic                 w_full;
    logic                 w_start_ok;
    logic                 w_wr_do;
    logic                 w_last;
    logic                 w_fail;
    logic [C_IDX_W-1:0]   w_idx_inc;

    assign w_full     = (r_count == C_CNT_W'(DEPTH));
    assign w_start_ok = ena && start && (r_count != '0) && (r_state != S_PLAY);
    // start outranks a same-cycle write so the buffer is stable once playing
    assign w_wr_do    = wr_en && !clear && !w_start_ok && (r_state == S_IDLE) && !w_full;
    assign w_last     = (C_CNT_W'(r_idx) == (r_count - C_CNT_W'(1)));
    assign w_fail     = (obs_in != r_exp_mem[r_idx]);
    assign w_idx_inc  = r_idx + C_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (w_wr_do) begin
            r_stim_mem[r_wr_ptr] <= wr_data[IO_W-1:0];
            r_exp_mem[r_wr_ptr]  <= wr_data[2*IO_W-1:IO_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_idx        <= '0;
            r_first_fail <= '0;
            r_timer      <= '0;
            r_mcnt       <= '0;
            r_stim       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_idx        <= w_idx_nxt;
            r_first_fail <= w_first_fail_nxt;
            r_timer      <= w_timer_nxt;
            r_mcnt       <= w_mcnt_nxt;
            r_stim       <= w_stim_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_idx_nxt        = r_idx;
        w_first_fail_nxt = r_first_fail;
        w_timer_nxt      = r_timer;
        w_mcnt_nxt       = r_mcnt;
        w_stim_nxt       = r_stim;

        if (clear) begin
            w_state_nxt      = S_IDLE;
            w_count_nxt      = '0;
            w_wr_ptr_nxt     = '0;
            w_idx_nxt        = '0;
            w_first_fail_nxt = '0;
            w_timer_nxt      = '0;
            w_mcnt_nxt       = '0;
            w_stim_nxt       = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        w_state_nxt      = S_PLAY;
                        w_idx_nxt        = '0;
                        w_timer_nxt      = div;
                        w_mcnt_nxt       = '0;
                        w_first_fail_nxt = '0;
                        w_stim_nxt       = r_stim_mem[0];
                    end else if (w_wr_do) begin
                        w_wr_ptr_nxt = r_wr_ptr + C_IDX_W'(1);
                        w_count_nxt  = r_count + C_CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    if (ena) begin
                        if (r_timer != '0) begin
                            w_timer_nxt = r_timer - DIV_W'(1);
                        end else begin
                            // A zero count means no mismatch yet; saturation never returns to zero
                            if (w_fail) begin
                                if (r_mcnt != '1) begin
                                    w_mcnt_nxt = r_mcnt + C_MC_W'(1);
                                end
                                if (r_mcnt == '0) begin
                                    w_first_fail_nxt = r_idx;
                                end
                            end
                            w_timer_nxt = div;
                            if (w_last) begin
                                if (loop_en) begin
                                    w_idx_nxt  = '0;
                                    w_stim_nxt = r_stim_mem[0];
                                end else begin
                                    w_state_nxt = S_DONE;
                                end
                            end else begin
                                w_idx_nxt  = w_idx_inc;
                                w_stim_nxt = r_stim_mem[w_idx_inc];
                            end
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign wr_full      = w_full;
    assign stim_out     = r_stim;
    assign busy         = (r_state == S_PLAY);
    assign done         = (r_state == S_DONE);
    assign mismatch_cnt = r_mcnt;
    assign first_fail   = r_first_fail;

endmodule
`default_nettype wire
